// File: rtl/float_pkg.sv
// Shared IEEE 754 single-precision field layout and constants.
package float_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  typedef struct packed {
    logic             sig;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  localparam float_t FLOAT_ZERO       = '{sig: 1'b0, exp: '0,    man: '0};
  localparam float_t FLOAT_MAX_FINITE = '{sig: 1'b0, exp: 8'hFE, man: '1};

endpackage

// File: rtl/fixed_mul_nb.sv
// Fully pipelined unsigned multiplier, STEPS-cycle latency.
// Stage s adds a * b[s*CH +: CH] << (s*CH) to the running partial product.
module fixed_mul_nb #(
  parameter int WIDTH = 24,
  parameter int STEPS = 24
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               din_valid,
  output logic [2*WIDTH-1:0] product,
  output logic               dout_valid
);

  localparam int CH = WIDTH / STEPS;

  if ((WIDTH % STEPS) != 0) begin : g_bad_steps
    $error("fixed_mul_nb: STEPS must divide WIDTH");
  end

  logic [WIDTH-1:0]   r_a   [STEPS];
  logic [WIDTH-1:0]   r_b   [STEPS];
  logic [2*WIDTH-1:0] r_acc [STEPS];
  logic               r_vld [STEPS];

  function automatic logic [2*WIDTH-1:0] partial(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input int unsigned      s);
    logic [WIDTH-1:0] ys;
    logic [CH-1:0]    c;
    ys = y >> (s * CH);
    c  = ys[CH-1:0];
    return ({{WIDTH{1'b0}}, x} * {{(2*WIDTH-CH){1'b0}}, c}) << (s * CH);
  endfunction

  // Valid chain, cleared by reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned s = 0; s < STEPS; s++) r_vld[s] <= 1'b0;
    end else begin
      r_vld[0] <= din_valid;
      for (int unsigned s = 1; s < STEPS; s++) r_vld[s] <= r_vld[s-1];
    end
  end

  // Operand and partial-product pipeline, not reset.
  always_ff @(posedge clk) begin
    r_a[0]   <= a;
    r_b[0]   <= b;
    r_acc[0] <= partial(a, b, 0);
    for (int unsigned s = 1; s < STEPS; s++) begin
      r_a[s]   <= r_a[s-1];
      r_b[s]   <= r_b[s-1];
      r_acc[s] <= r_acc[s-1] + partial(r_a[s-1], r_b[s-1], s);
    end
  end

  assign product    = r_acc[STEPS-1];
  assign dout_valid = r_vld[STEPS-1];

endmodule

// File: rtl/shift_reg.sv
// Valid-gated delay line: din appears on dout exactly DEPTH cycles later.
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_vld  [DEPTH];

  // Valid chain, cleared by reset so nothing in flight survives it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= din_valid;
      for (int unsigned i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Data chain, not reset.
  always_ff @(posedge clk) begin
    r_data[0] <= din;
    for (int unsigned i = 1; i < DEPTH; i++) r_data[i] <= r_data[i-1];
  end

  assign dout       = r_data[DEPTH-1];
  assign dout_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/float_mul_nb.sv
// Pipelined IEEE 754 single multiplier, round-to-zero, denormals flushed.
// Latency MUL_STEPS + 2: input register, mantissa multiplier, normalise.
module float_mul_nb
  import float_pkg::*;
#(
  parameter int MUL_STEPS = 24
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid
);

  localparam int SIDE_W = 12;

  float_t w_a, w_b;
  assign w_a = din1;
  assign w_b = din2;

  logic        r_s0_valid;
  logic        r_s0_sign;
  logic        r_s0_zero;
  logic [9:0]  r_s0_exp;
  logic [23:0] r_s0_ma;
  logic [23:0] r_s0_mb;

  // Stage 0 valid.
  always_ff @(posedge clk) begin
    if (!nrst) r_s0_valid <= 1'b0;
    else       r_s0_valid <= din_valid;
  end

  // Stage 0 data: unpack fields, biased exponent sum as 10-bit signed.
  always_ff @(posedge clk) begin
    r_s0_zero <= (w_a.exp == '0) | (w_b.exp == '0);
    r_s0_sign <= w_a.sig ^ w_b.sig;
    r_s0_exp  <= {2'b00, w_a.exp} + {2'b00, w_b.exp} - 10'(BIAS);
    r_s0_ma   <= {1'b1, w_a.man};
    r_s0_mb   <= {1'b1, w_b.man};
  end

  logic [47:0]       w_p;
  logic              w_mul_valid;
  logic [SIDE_W-1:0] w_side;
  logic              w_side_valid;

  fixed_mul_nb #(.WIDTH(24), .STEPS(MUL_STEPS)) u_mul (
    .clk        (clk),
    .nrst       (nrst),
    .a          (r_s0_ma),
    .b          (r_s0_mb),
    .din_valid  (r_s0_valid),
    .product    (w_p),
    .dout_valid (w_mul_valid)
  );

  shift_reg #(.WIDTH(SIDE_W), .DEPTH(MUL_STEPS)) u_side (
    .clk        (clk),
    .nrst       (nrst),
    .din        ({r_s0_sign, r_s0_exp, r_s0_zero}),
    .din_valid  (r_s0_valid),
    .dout       (w_side),
    .dout_valid (w_side_valid)
  );

  logic        w_sign;
  logic        w_zero;
  logic [9:0]  w_exp;
  logic [9:0]  w_exp_res;
  logic [22:0] w_man;
  logic        w_st_valid;
  float_t      w_res;
  logic        w_unused_lsbs;

  assign {w_sign, w_exp, w_zero} = w_side;
  assign w_st_valid    = w_mul_valid & w_side_valid;
  assign w_unused_lsbs = ^w_p[22:0];

  // Normalise the product and select zero / saturate / normal result.
  always_comb begin
    w_exp_res = w_exp;
    w_man     = w_p[45:23];
    if (w_p[47]) begin
      w_exp_res = w_exp + 10'd1;
      w_man     = w_p[46:24];
    end
    w_res = '{sig: w_sign, exp: w_exp_res[7:0], man: w_man};
    if (w_zero) begin
      w_res = FLOAT_ZERO;
    end else if (w_exp_res[9] || (w_exp_res == '0)) begin
      w_res = FLOAT_ZERO;
    end else if (w_exp_res >= 10'd255) begin
      w_res = '{sig: w_sign, exp: FLOAT_MAX_FINITE.exp, man: FLOAT_MAX_FINITE.man};
    end
  end

  // Output register; dout holds between results.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= w_st_valid;
      if (w_st_valid) dout <= w_res;
    end
  end

endmodule

// File: doc/float_mul_nb.md
Name: float_mul_nb

Overview:
- Non-blocking, fully pipelined IEEE 754 single-precision multiplier: dout = din1 * din2.
- Accepts one operand pair per cycle and emits results in order after a fixed latency.
- Complements the float divider in the quantisation and scaling datapath, for the rescale steps that multiply by a reciprocal.
- Rounding is round-to-zero.
- Denormal inputs are flushed to zero.
- Inf/NaN are not supported as inputs.

Parameters:
- MUL_STEPS, 24, number of pipeline stages in the mantissa multiplier.
  - Legal values: 1, 2, 3, 4, 6, 8, 12, 24.
  - Each stage consumes 24/MUL_STEPS multiplier bits.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- din1  in  32  operand A, IEEE 754 single.
- din2  in  32  operand B, IEEE 754 single.
- din_valid  in  1  operand pair valid this cycle.
- dout  out  32  product, IEEE 754 single.
- dout_valid  out  1  dout valid this cycle (single-cycle pulse per result).

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous and active-low.
- Reset values:
  - Every valid flag in the pipeline is 0, so dout_valid=0.
  - dout=32'h0.
  - Internal data registers are not reset.
- Reset mid-operation: all in-flight results are discarded. No dout_valid pulse appears for any pair accepted before the reset cycle.
- Flow: no back-pressure. A pair is accepted every cycle that din_valid=1. Valid bubbles propagate unchanged.
- Latency: L = MUL_STEPS + 2 cycles, which is 26 at the default. din_valid at cycle t gives dout_valid at cycle t+L.
- Stage 0 (input register):
  - zero_flag = (exp1==0) | (exp2==0).
  - sign = sig1 ^ sig2.
  - exp_sum = {2'b0,exp1} + {2'b0,exp2} - 127, a 10-bit two's complement value.
  - ma = {1,man1}, mb = {1,man2}, each 24 bits.
- Multiplier stages: fixed_mul_nb computes the 48-bit unsigned product P = ma*mb, with a partial product accumulated per stage.
  - sign, exp_sum and zero_flag travel alongside in a MUL_STEPS-deep shift register gated by the same valid.
- Output stage (normalise, registered):
  - If P[47]=1: man = P[46:24], exp_res = exp_sum + 1.
  - Otherwise: man = P[45:23], exp_res = exp_sum.
  - Discarded low bits are truncated (round-to-zero).
- Output selection, in priority order:
  - zero_flag = 1: dout = 32'h0, with sign forced to 0.
  - exp_res <= 0 (signed, underflow): dout = 32'h0, with sign forced to 0.
  - exp_res >= 255 (overflow): dout = {sign, 8'hFE, 23'h7FFFFF}, the RTZ max finite value.
  - Otherwise: dout = {sign, exp_res[7:0], man}.
- Inputs with exp==8'hFF are processed as ordinary normals. The result is undefined-but-deterministic, and the bench does not check it.
- dout holds its last value while dout_valid=0.

Decomposition:
- Shared package float_pkg:
  - Field widths: EXP_W=8, MAN_W=23, BIAS=127.
  - Packed struct float_t {sig, exp, man}.
  - Constants FLOAT_ZERO and FLOAT_MAX_FINITE.
- Sub-module fixed_mul_nb:
  - Parameters: WIDTH=24, STEPS.
  - Ports: clk, nrst, a, b, din_valid, product[2*WIDTH-1:0], dout_valid.
  - Fixed STEPS-cycle latency, fully pipelined.
  - Reused by other fixed-point blocks.
- Reuse the existing shift_reg for the sign/exponent/zero side pipeline.

Test Plan:
- Basic product, sign and normalisation:
  - 0x40000000*0x40400000 (2*3) -> 0x40C00000 after exactly 26 cycles.
  - 0x3FC00000*0x3FC00000 (1.5^2) -> 0x40100000, exercising the P[47]=1 path.
  - 0xBF800000*0x3F000000 -> 0xBF000000.
- Rounding: 0x3F800001*0x3F800001 -> 0x3F800002, confirming truncation (RTZ).
- Zero and denormal flush:
  - 0x00000000*0xC0490FDB -> 0x00000000.
  - 0x80000000*0x3F800000 -> 0x00000000.
  - 0x00000001*0x7F000000 -> 0x00000000.
- Exponent boundaries:
  - 0x7F000000*0x7F000000 -> 0x7F7FFFFF.
  - 0xFF000000*0x7F000000 -> 0xFF7FFFFF.
  - 0x00800000*0x00800000 -> 0x00000000 (underflow).
- Streaming: 200 random normal pairs with random din_valid gaps -> dout matches the reference model in order, and the dout_valid pulse count equals the accepted count.
- Reset mid-stream: assert nrst=0 for 1 cycle with 10 pairs in flight -> no dout_valid for those pairs; the first pair accepted after reset emerges at t+26 with the correct value.
